// File: rtl/pwm_pkg.sv
// ============================================================================
// Module : pwm_pkg
// Brief  : Shared constants and FSM state encoding for the servo PWM blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int PWM_MIN_HIGH = 64;
    localparam int PWM_DUTY_W   = 8;

    localparam logic [1:0] ST_SYNC      = 2'd0;
    localparam logic [1:0] ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] ST_MEAS_HIGH = 2'd2;
    localparam logic [1:0] ST_MEAS_LOW  = 2'd3;

    typedef enum logic [1:0] {
        SYNC      = ST_SYNC,
        WAIT_RISE = ST_WAIT_RISE,
        MEAS_HIGH = ST_MEAS_HIGH,
        MEAS_LOW  = ST_MEAS_LOW
    } pwm_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_sync_edge.sv
// ============================================================================
// Module : pwm_sync_edge
// Brief  : 2-flop synchronizer, optional 3-tap majority filter
//          (PWM_CAP_FILTER_EN), registered level and rise/fall pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_sync_edge (
    input  logic clockdiv,
    input  logic reset,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic w_s;
    logic r_level;
    logic r_rise;
    logic r_fall;

    // Chain resets high so a pulse already in progress at reset never looks like a rise.
    always_ff @(posedge clockdiv) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_pwm;
            r_sync <= r_meta;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    logic r_tap1;
    logic r_tap2;
    logic r_filt;

    always_ff @(posedge clockdiv) begin
        if (reset) begin
            r_tap1 <= 1'b1;
            r_tap2 <= 1'b1;
            r_filt <= 1'b1;
        end else begin
            r_tap1 <= r_sync;
            r_tap2 <= r_tap1;
            r_filt <= (r_sync & r_tap1) | (r_sync & r_tap2) | (r_tap1 & r_tap2);
        end
    end

    assign w_s = r_filt;
`else
    assign w_s = r_sync;
`endif

    always_ff @(posedge clockdiv) begin
        if (reset) begin
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_level <= w_s;
            r_rise  <= w_s & ~r_level;
            r_fall  <= ~w_s & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// Module : pwm_capture
// Brief  : Servo-PWM receiver; decodes high time into an 8-bit duty code and
//          flags range errors and signal loss. Optional PWM_CAP_FILTER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned ENDCOUNT = 2559,
    parameter int unsigned MIN_HIGH = PWM_MIN_HIGH,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic                  clockdiv,
    input  logic                  reset,
    input  logic                  pwm_in,
    output logic [PWM_DUTY_W-1:0] duty,
    output logic                  valid,
    output logic                  range_err,
    output logic                  lost
);

    // A timeout no longer than one period would flag healthy signals as lost.
    localparam int unsigned c_timeout = (TIMEOUT > ENDCOUNT) ? TIMEOUT : ENDCOUNT + 1;
    localparam int unsigned c_max_high = MIN_HIGH + (2 ** PWM_DUTY_W) - 1;

    pwm_state_t  r_state;
    pwm_state_t  w_next;
    logic        w_level;
    logic        w_rise;
    logic        w_fall;
    logic        w_timeout;
    logic        w_decode;
    logic [9:0]  r_width;
    logic [12:0] r_idle;

    pwm_sync_edge u_sync_edge (
        .clockdiv (clockdiv),
        .reset    (reset),
        .i_pwm    (pwm_in),
        .o_level  (w_level),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    assign w_timeout = ~w_rise && (r_idle == 13'(c_timeout - 1));
    assign w_decode  = (r_state == MEAS_HIGH) && w_fall && ~w_timeout;

    always_ff @(posedge clockdiv) begin
        if (reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SYNC:      if (!w_level) w_next = WAIT_RISE;
            WAIT_RISE: if (w_rise)   w_next = MEAS_HIGH;
            MEAS_HIGH: if (w_fall)   w_next = MEAS_LOW;
            MEAS_LOW:  if (w_rise)   w_next = MEAS_HIGH;
            default:                 w_next = SYNC;
        endcase
        if (w_timeout) begin
            w_next = SYNC;
        end
    end

    always_ff @(posedge clockdiv) begin
        if (reset) begin
            r_width   <= '0;
            r_idle    <= '0;
            duty      <= '0;
            valid     <= 1'b0;
            range_err <= 1'b0;
            lost      <= 1'b1;
        end else begin
            valid <= w_decode;

            // The rise cycle is itself the first high cycle, so the count restarts at one.
            if (w_rise && (r_state == WAIT_RISE || r_state == MEAS_LOW)) begin
                r_width <= 10'd1;
            end else if (r_state == MEAS_HIGH && w_level && r_width != '1) begin
                r_width <= r_width + 10'd1;
            end

            if (w_rise) begin
                r_idle <= '0;
                lost   <= 1'b0;
            end else begin
                if (r_idle != '1) begin
                    r_idle <= r_idle + 13'd1;
                end
                if (w_timeout) begin
                    lost <= 1'b1;
                end
            end

            if (w_decode) begin
                if (r_width < 10'(MIN_HIGH)) begin
                    duty      <= '0;
                    range_err <= 1'b1;
                end else if (r_width > 10'(c_max_high)) begin
                    duty      <= '1;
                    range_err <= 1'b1;
                end else begin
                    duty      <= PWM_DUTY_W'(r_width - 10'(MIN_HIGH));
                    range_err <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire
